yolo_op_sequencer: RTL and testbench

YOLO_OP_SEQUENCER -- requirements
Module: yolo_op_sequencer

---
 rtl/yolo_op_sequencer_pkg.sv | 39 +++
 rtl/yolo_cmd_hold.sv | 43 ++++
 rtl/yolo_op_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_yolo_op_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_op_sequencer_pkg.sv
// Shared types and field layout for the YOLO two-pass op sequencer.
// Holds the FSM state type, inst_2 field positions, command widths and a saturating adder.
package yolo_op_sequencer_pkg;

  localparam int unsigned AddrW     = 32;
  localparam int unsigned RdLenW    = 18;
  localparam int unsigned WrLenW    = 16;
  localparam int unsigned RespW     = 2;
  localparam int unsigned BoxW      = 16;

  // Field positions inside inst_2.
  localparam int unsigned L0LenLsb  = 0;
  localparam int unsigned L0LenW    = 16;
  localparam int unsigned AnchorLsb = 24;
  localparam int unsigned AnchorW   = 4;

  typedef enum logic [3:0] {
    StIdle,
    StRd0,
    StRd0W,
    StDp0,
    StDp0W,
    StRd1,
    StRd1W,
    StDp1,
    StDp1W,
    StWr,
    StWrW,
    StDone
  } seq_state_e;

  function automatic logic [BoxW-1:0] sat_add(input logic [BoxW-1:0] a,
                                               input logic [BoxW-1:0] b);
    logic [BoxW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[BoxW] ? {BoxW{1'b1}} : sum[BoxW-1:0];
  endfunction

endpackage

// File: rtl/yolo_cmd_hold.sv
// Valid/ready command holding register: load captures addr/len and raises valid,
// which then stays high with stable payload until the consumer signals ready.
module yolo_cmd_hold
  import yolo_op_sequencer_pkg::*;
#(
  parameter int unsigned AddrBits = AddrW,
  parameter int unsigned LenBits  = WrLenW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [AddrBits-1:0] addr_i,
  input  logic [LenBits-1:0]  len_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [AddrBits-1:0] addr_o,
  output logic [LenBits-1:0]  len_o
);

  logic                valid_q;
  logic [AddrBits-1:0] addr_q;
  logic [LenBits-1:0]  len_q;

  // Payload is kept after acceptance so the issued address stays observable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      len_q   <= len_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign len_o   = len_q;

endmodule

// File: rtl/yolo_op_sequencer.sv
// Job sequencer: read head 0, run datapath layer 0, read head 1, run layer 1,
// then write the accumulated box count; raises IRQ on completion or error.
module yolo_op_sequencer
  import yolo_op_sequencer_pkg::*;
(
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  input  logic               s_axi_start,
  input  logic [31:0]        s_axi_inst_0,
  input  logic [31:0]        s_axi_inst_1,
  input  logic [31:0]        s_axi_inst_2,
  input  logic [31:0]        s_axi_inst_3,
  input  logic [31:0]        s_axi_inst_4,
  input  logic [31:0]        s_axi_inst_5,
  output logic               IRQ,
  output logic               s_axi_Rerror,
  output logic [AddrW-1:0]   s_axi_Rerror_addr,
  output logic [RespW-1:0]   s_axi_Werror,
  output logic [AddrW-1:0]   s_axi_Werror_addr,
  output logic               rd_cmd_valid,
  input  logic               rd_cmd_ready,
  output logic [AddrW-1:0]   rd_cmd_addr,
  output logic [RdLenW-1:0]  rd_cmd_len,
  input  logic               rd_done,
  input  logic               rd_err,
  output logic               wr_cmd_valid,
  input  logic               wr_cmd_ready,
  output logic [AddrW-1:0]   wr_cmd_addr,
  output logic [WrLenW-1:0]  wr_cmd_len,
  input  logic               wr_done,
  input  logic [RespW-1:0]   wr_resp,
  output logic               dp_start,
  output logic               dp_layer,
  output logic [AnchorW-1:0] dp_anchors,
  output logic [31:0]        dp_thresh,
  output logic [31:0]        dp_img_base,
  input  logic               dp_done,
  input  logic [BoxW-1:0]    dp_box_cnt
);

  seq_state_e state_q, state_d;

  logic               start_q;
  logic               start_edge;
  logic               job_accept;

  logic [AddrW-1:0]   inst1_q;
  logic [L0LenW-1:0]  l0_len_q;
  logic [AnchorW-1:0] anchors_q;
  logic [31:0]        thresh_q;
  logic [31:0]        img_base_q;
  logic [AddrW-1:0]   inst5_q;

  logic [BoxW-1:0]    box_q, box_d;
  logic               rerr_q, rerr_d;
  logic [AddrW-1:0]   rerr_addr_q, rerr_addr_d;
  logic [RespW-1:0]   werr_q, werr_d;
  logic [AddrW-1:0]   werr_addr_q, werr_addr_d;

  logic               rd_load;
  logic [AddrW-1:0]   rd_addr_ld;
  logic [RdLenW-1:0]  rd_len_ld;
  logic               wr_load;
  logic               rd_accept;
  logic               wr_accept;

  logic               unused_inst2;
  assign unused_inst2 = ^{s_axi_inst_2[31:28], s_axi_inst_2[23:16]};

  assign start_edge = s_axi_start && !start_q;
  assign rd_accept  = rd_cmd_valid && rd_cmd_ready;
  assign wr_accept  = wr_cmd_valid && wr_cmd_ready;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      box_q       <= '0;
      rerr_q      <= 1'b0;
      rerr_addr_q <= '0;
      werr_q      <= '0;
      werr_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= s_axi_start;
      box_q       <= box_d;
      rerr_q      <= rerr_d;
      rerr_addr_q <= rerr_addr_d;
      werr_q      <= werr_d;
      werr_addr_q <= werr_addr_d;
    end
  end

  // Job parameters are captured once per accepted start and held for the whole job.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      inst1_q    <= '0;
      l0_len_q   <= '0;
      anchors_q  <= '0;
      thresh_q   <= '0;
      img_base_q <= '0;
      inst5_q    <= '0;
    end else if (job_accept) begin
      inst1_q    <= s_axi_inst_1;
      l0_len_q   <= s_axi_inst_2[L0LenLsb +: L0LenW];
      anchors_q  <= s_axi_inst_2[AnchorLsb +: AnchorW];
      thresh_q   <= s_axi_inst_3;
      img_base_q <= s_axi_inst_4;
      inst5_q    <= s_axi_inst_5;
    end
  end

  always_comb begin
    state_d     = state_q;
    box_d       = box_q;
    rerr_d      = rerr_q;
    rerr_addr_d = rerr_addr_q;
    werr_d      = werr_q;
    werr_addr_d = werr_addr_q;
    job_accept  = 1'b0;
    rd_load     = 1'b0;
    rd_addr_ld  = '0;
    rd_len_ld   = '0;
    wr_load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          job_accept  = 1'b1;
          box_d       = '0;
          rerr_d      = 1'b0;
          rerr_addr_d = '0;
          werr_d      = '0;
          werr_addr_d = '0;
          // Command is loaded on the way in so valid is up for the whole RD0 state.
          rd_load     = 1'b1;
          rd_addr_ld  = s_axi_inst_0;
          rd_len_ld   = RdLenW'(s_axi_inst_2[L0LenLsb +: L0LenW]);
          state_d     = StRd0;
        end
      end
      StRd0: if (rd_accept) state_d = StRd0W;
      StRd0W, StRd1W: begin
        if (rd_done) begin
          if (rd_err) begin
            rerr_d      = 1'b1;
            rerr_addr_d = rd_cmd_addr;
            state_d     = StDone;
          end else begin
            state_d = (state_q == StRd0W) ? StDp0 : StDp1;
          end
        end
      end
      StDp0: state_d = StDp0W;
      StDp0W: begin
        if (dp_done) begin
          box_d      = sat_add(box_q, dp_box_cnt);
          rd_load    = 1'b1;
          rd_addr_ld = inst1_q;
          rd_len_ld  = RdLenW'({l0_len_q, 2'b00});
          state_d    = StRd1;
        end
      end
      StRd1: if (rd_accept) state_d = StRd1W;
      StDp1: state_d = StDp1W;
      StDp1W: begin
        if (dp_done) begin
          box_d = sat_add(box_q, dp_box_cnt);
          if (box_d != '0) begin
            wr_load = 1'b1;
            state_d = StWr;
          end else begin
            state_d = StDone;
          end
        end
      end
      StWr: if (wr_accept) state_d = StWrW;
      StWrW: begin
        if (wr_done) begin
          if (wr_resp != '0) begin
            werr_d      = wr_resp;
            werr_addr_d = inst5_q;
          end
          state_d = StDone;
        end
      end
      StDone: if (!s_axi_start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  yolo_cmd_hold #(
    .AddrBits(AddrW),
    .LenBits (RdLenW)
  ) u_rd_hold (
    .clk_i  (S_AXI_ACLK),
    .rst_i  (S_AXI_ARESET),
    .load_i (rd_load),
    .addr_i (rd_addr_ld),
    .len_i  (rd_len_ld),
    .ready_i(rd_cmd_ready),
    .valid_o(rd_cmd_valid),
    .addr_o (rd_cmd_addr),
    .len_o  (rd_cmd_len)
  );

  yolo_cmd_hold #(
    .AddrBits(AddrW),
    .LenBits (WrLenW)
  ) u_wr_hold (
    .clk_i  (S_AXI_ACLK),
    .rst_i  (S_AXI_ARESET),
    .load_i (wr_load),
    .addr_i (inst5_q),
    .len_i  (box_d),
    .ready_i(wr_cmd_ready),
    .valid_o(wr_cmd_valid),
    .addr_o (wr_cmd_addr),
    .len_o  (wr_cmd_len)
  );

  assign IRQ               = (state_q == StDone);
  assign s_axi_Rerror      = rerr_q;
  assign s_axi_Rerror_addr = rerr_addr_q;
  assign s_axi_Werror      = werr_q;
  assign s_axi_Werror_addr = werr_addr_q;
  assign dp_start          = (state_q == StDp0) || (state_q == StDp1);
  assign dp_layer          = (state_q == StDp1);
  assign dp_anchors        = anchors_q;
  assign dp_thresh         = thresh_q;
  assign dp_img_base       = img_base_q;

endmodule

// File: tb/tb_yolo_op_sequencer.sv
// Self-checking bench for yolo_op_sequencer: table vectors, random jobs against a
// job-level reference model, and hand-written reset corner sequences.
module tb_yolo_op_sequencer;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESET = 1'b1;
  logic        s_axi_start = 1'b0;
  logic [31:0] s_axi_inst_0 = '0, s_axi_inst_1 = '0, s_axi_inst_2 = '0;
  logic [31:0] s_axi_inst_3 = '0, s_axi_inst_4 = '0, s_axi_inst_5 = '0;
  logic        IRQ, s_axi_Rerror, rd_cmd_valid, wr_cmd_valid, dp_start, dp_layer;
  logic [31:0] s_axi_Rerror_addr, s_axi_Werror_addr, rd_cmd_addr, wr_cmd_addr;
  logic [31:0] dp_thresh, dp_img_base;
  logic [1:0]  s_axi_Werror;
  logic [17:0] rd_cmd_len;
  logic [15:0] wr_cmd_len;
  logic [3:0]  dp_anchors;
  logic        rd_cmd_ready = 1'b0, rd_done = 1'b0, rd_err = 1'b0;
  logic        wr_cmd_ready = 1'b0, wr_done = 1'b0, dp_done = 1'b0;
  logic [1:0]  wr_resp = '0;
  logic [15:0] dp_box_cnt = '0;

  int total = 0;
  int bad = 0;

  yolo_op_sequencer dut (
    .S_AXI_ACLK       (S_AXI_ACLK),
    .S_AXI_ARESET     (S_AXI_ARESET),
    .s_axi_start      (s_axi_start),
    .s_axi_inst_0     (s_axi_inst_0),
    .s_axi_inst_1     (s_axi_inst_1),
    .s_axi_inst_2     (s_axi_inst_2),
    .s_axi_inst_3     (s_axi_inst_3),
    .s_axi_inst_4     (s_axi_inst_4),
    .s_axi_inst_5     (s_axi_inst_5),
    .IRQ              (IRQ),
    .s_axi_Rerror     (s_axi_Rerror),
    .s_axi_Rerror_addr(s_axi_Rerror_addr),
    .s_axi_Werror     (s_axi_Werror),
    .s_axi_Werror_addr(s_axi_Werror_addr),
    .rd_cmd_valid     (rd_cmd_valid),
    .rd_cmd_ready     (rd_cmd_ready),
    .rd_cmd_addr      (rd_cmd_addr),
    .rd_cmd_len       (rd_cmd_len),
    .rd_done          (rd_done),
    .rd_err           (rd_err),
    .wr_cmd_valid     (wr_cmd_valid),
    .wr_cmd_ready     (wr_cmd_ready),
    .wr_cmd_addr      (wr_cmd_addr),
    .wr_cmd_len       (wr_cmd_len),
    .wr_done          (wr_done),
    .wr_resp          (wr_resp),
    .dp_start         (dp_start),
    .dp_layer         (dp_layer),
    .dp_anchors       (dp_anchors),
    .dp_thresh        (dp_thresh),
    .dp_img_base      (dp_img_base),
    .dp_done          (dp_done),
    .dp_box_cnt       (dp_box_cnt)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [5:0][31:0] inst;
    logic [15:0]      b0, b1;
    int               rd_err_at;   // 0 none, 1 first read, 2 second read
    logic [1:0]       wr_resp;
    int               rdy_dly;
    bit               stray;
    int               exp_n_rd;
    logic [15:0]      exp_wr_len;  // 0 means no write expected
    logic             exp_rerr;
    logic [1:0]       exp_werr;
  } vec_t;

  typedef struct {
    int          n_rd, n_dp, n_wr;
    logic [31:0] ra0, ra1, rea;
    logic [17:0] rl0, rl1;
    logic        wr;
    logic [31:0] wa, wea;
    logic [15:0] wl;
    logic        rerr;
    logic [1:0]  werr;
  } exp_t;

  typedef struct {
    int          n_rd, n_dp, n_wr, irq_lat, vcyc0;
    logic [31:0] ra0, ra1, wa, rea, wea;
    logic [17:0] rl0, rl1;
    logic [15:0] wl;
    logic        rerr, rerr2, irq_seen, irq_hold_ok, irq_clr, err_clr, dp_ok, stable_ok;
    logic [1:0]  werr, werr2;
  } obs_t;

  function automatic vec_t mk(input logic [5:0][31:0] inst, input logic [15:0] b0,
                              input logic [15:0] b1, input int err, input logic [1:0] resp,
                              input int dly, input bit stray, input int en_rd,
                              input logic [15:0] ewl, input logic erer, input logic [1:0] ewer);
    vec_t v;
    v.inst = inst; v.b0 = b0; v.b1 = b1; v.rd_err_at = err; v.wr_resp = resp;
    v.rdy_dly = dly; v.stray = stray; v.exp_n_rd = en_rd; v.exp_wr_len = ewl;
    v.exp_rerr = erer; v.exp_werr = ewer;
    return v;
  endfunction

  // Job-level reference: what one job must produce, from the words and responses alone.
  function automatic exp_t model(input vec_t v);
    exp_t        e;
    int unsigned l0, sum;
    e = '{default: '0};
    l0 = v.inst[2] & 32'hFFFF;
    e.ra0 = v.inst[0];
    e.rl0 = 18'(l0);
    e.ra1 = v.inst[1];
    e.rl1 = 18'(l0 * 4);
    e.n_rd = (v.rd_err_at == 1) ? 1 : 2;
    e.n_dp = (v.rd_err_at == 1) ? 0 : (v.rd_err_at == 2) ? 1 : 2;
    if (v.rd_err_at != 0) begin
      e.rerr = 1'b1;
      e.rea  = (v.rd_err_at == 1) ? v.inst[0] : v.inst[1];
    end else begin
      sum = int'(v.b0) + int'(v.b1);
      if (sum > 65535) sum = 65535;
      e.wr = (sum != 0);
      e.wl = 16'(sum);
      e.wa = v.inst[5];
      if (e.wr && v.wr_resp != 2'b00) begin
        e.werr = v.wr_resp;
        e.wea  = v.inst[5];
      end
    end
    e.n_wr = e.wr ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{IRQ, s_axi_Rerror, s_axi_Rerror_addr, s_axi_Werror, s_axi_Werror_addr,
             rd_cmd_valid, rd_cmd_addr, rd_cmd_len, wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
             dp_start, dp_layer, dp_anchors, dp_thresh, dp_img_base};
  endfunction

  // Plays the DMA and datapath around one job, recording what the DUT did.
  task automatic run_job(input vec_t v, output obs_t o);
    int          rd_cd, dp_cd, wr_cd, rd_wait, last_dp;
    logic [31:0] va;
    logic [17:0] vl;
    bit          vhold;
    o = '{default: '0};
    o.stable_ok = 1'b1; o.dp_ok = 1'b1;
    rd_cd = 0; dp_cd = 0; wr_cd = 0; rd_wait = 0; last_dp = -100; vhold = 0;
    va = '0; vl = '0;
    @(negedge S_AXI_ACLK);
    {s_axi_inst_5, s_axi_inst_4, s_axi_inst_3, s_axi_inst_2, s_axi_inst_1, s_axi_inst_0} = v.inst;
    s_axi_start = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge S_AXI_ACLK);
      rd_done = 0; rd_err = 0; dp_done = 0; wr_done = 0; wr_resp = '0;
      rd_cmd_ready = 0; wr_cmd_ready = 0;
      if (cyc == 0)
        o.err_clr = !(s_axi_Rerror || s_axi_Werror != 0 || s_axi_Rerror_addr != 0 ||
                      s_axi_Werror_addr != 0);
      if (dp_anchors != v.inst[2][27:24] || dp_thresh != v.inst[3] || dp_img_base != v.inst[4])
        o.dp_ok = 1'b0;
      if (IRQ) begin
        o.irq_seen = 1'b1;
        o.irq_lat = cyc - last_dp;
        o.rerr = s_axi_Rerror; o.rea = s_axi_Rerror_addr;
        o.werr = s_axi_Werror; o.wea = s_axi_Werror_addr;
        break;
      end
      if (rd_cmd_valid) begin
        if (vhold && (rd_cmd_addr != va || rd_cmd_len != vl)) o.stable_ok = 1'b0;
        va = rd_cmd_addr; vl = rd_cmd_len; vhold = 1;
        if (o.n_rd == 0) o.vcyc0++;
        if (rd_wait >= v.rdy_dly) begin
          rd_cmd_ready = 1;
          if (o.n_rd == 0) begin o.ra0 = va; o.rl0 = vl; end
          else if (o.n_rd == 1) begin o.ra1 = va; o.rl1 = vl; end
          o.n_rd++;
          rd_cd = 3; rd_wait = 0; vhold = 0;
        end else begin
          rd_wait++;
        end
      end else if (rd_cd > 0) begin
        rd_cd--;
        if (v.stray && rd_cd == 2) begin
          dp_done = 1; dp_box_cnt = 16'h1234; wr_done = 1; wr_resp = 2'b11;
        end
        if (rd_cd == 0) begin
          rd_done = 1; rd_err = (o.n_rd == v.rd_err_at);
        end
      end
      if (dp_start) begin
        if (dp_layer != (o.n_dp == 1)) o.dp_ok = 1'b0;
        o.n_dp++; dp_cd = 2;
      end else if (dp_cd > 0) begin
        dp_cd--;
        if (dp_cd == 0) begin
          dp_done = 1; dp_box_cnt = (o.n_dp == 1) ? v.b0 : v.b1; last_dp = cyc;
        end
      end
      if (wr_cmd_valid) begin
        wr_cmd_ready = 1; o.n_wr++; o.wa = wr_cmd_addr; o.wl = wr_cmd_len; wr_cd = 3;
      end else if (wr_cd > 0) begin
        wr_cd--;
        if (wr_cd == 0) begin wr_done = 1; wr_resp = v.wr_resp; end
      end
    end
    rd_done = 0; dp_done = 0; wr_done = 0; wr_resp = '0; rd_cmd_ready = 0; wr_cmd_ready = 0;
    o.irq_hold_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge S_AXI_ACLK);
      if (!IRQ) o.irq_hold_ok = 1'b0;
    end
    s_axi_start = 1'b0;
    @(negedge S_AXI_ACLK);
    o.irq_clr = !IRQ;
    @(negedge S_AXI_ACLK);
    o.rerr2 = s_axi_Rerror; o.werr2 = s_axi_Werror;
  endtask

  task automatic compare(input string tag, input vec_t v, input obs_t o, input bit use_tbl);
    exp_t e;
    e = model(v);
    chk({tag, "irq_seen"}, 64'(o.irq_seen), 64'(1));
    chk({tag, "n_rd"}, 64'(o.n_rd), 64'(e.n_rd));
    chk({tag, "rd0_addr"}, 64'(o.ra0), 64'(e.ra0));
    chk({tag, "rd0_len"}, 64'(o.rl0), 64'(e.rl0));
    if (e.n_rd == 2) begin
      chk({tag, "rd1_addr"}, 64'(o.ra1), 64'(e.ra1));
      chk({tag, "rd1_len"}, 64'(o.rl1), 64'(e.rl1));
    end
    chk({tag, "rd0_valid_cycles"}, 64'(o.vcyc0), 64'(v.rdy_dly + 1));
    chk({tag, "rd_stable"}, 64'(o.stable_ok), 64'(1));
    chk({tag, "n_dp"}, 64'(o.n_dp), 64'(e.n_dp));
    chk({tag, "dp_ctrl"}, 64'(o.dp_ok), 64'(1));
    chk({tag, "n_wr"}, 64'(o.n_wr), 64'(e.n_wr));
    if (e.wr) begin
      chk({tag, "wr_addr"}, 64'(o.wa), 64'(e.wa));
      chk({tag, "wr_len"}, 64'(o.wl), 64'(e.wl));
    end
    if (!e.wr && v.rd_err_at == 0) chk({tag, "irq_latency_le2"}, 64'(o.irq_lat <= 2), 64'(1));
    chk({tag, "rerr"}, 64'(o.rerr), 64'(e.rerr));
    chk({tag, "rerr_addr"}, 64'(o.rea), 64'(e.rea));
    chk({tag, "werr"}, 64'(o.werr), 64'(e.werr));
    chk({tag, "werr_addr"}, 64'(o.wea), 64'(e.wea));
    chk({tag, "err_clear_on_start"}, 64'(o.err_clr), 64'(1));
    chk({tag, "irq_hold"}, 64'(o.irq_hold_ok), 64'(1));
    chk({tag, "irq_clear"}, 64'(o.irq_clr), 64'(1));
    chk({tag, "rerr_held"}, 64'(o.rerr2), 64'(e.rerr));
    chk({tag, "werr_held"}, 64'(o.werr2), 64'(e.werr));
    if (use_tbl) begin
      chk({tag, "tbl_n_rd"}, 64'(o.n_rd), 64'(v.exp_n_rd));
      chk({tag, "tbl_wr_len"}, 64'(o.n_wr != 0 ? o.wl : 16'h0), 64'(v.exp_wr_len));
      chk({tag, "tbl_rerr"}, 64'(o.rerr), 64'(v.exp_rerr));
      chk({tag, "tbl_werr"}, 64'(o.werr), 64'(v.exp_werr));
    end
  endtask

  initial begin
    vec_t             vecs[8];
    vec_t             rv;
    obs_t             ob;
    logic [5:0][31:0] ia, ri;
    int               e, cd;
    logic [15:0]      rb[2];
    bit               seen, moved;

    ia = {32'h00380c00, 32'h00280c00, 32'hFE52FCA4, 32'h030000c0, 32'h0027dc00, 32'h0023ec00};
    //            inst b0        b1        err resp   dly st  n_rd wr_len    rerr  werr
    vecs[0] = mk(ia, 16'd5,    16'd7,    0, 2'b00, 0,  0, 2, 16'd12,   1'b0, 2'b00);
    vecs[1] = mk(ia, 16'd5,    16'd7,    0, 2'b00, 10, 0, 2, 16'd12,   1'b0, 2'b00);
    vecs[2] = mk(ia, 16'd5,    16'd7,    2, 2'b00, 1,  0, 2, 16'd0,    1'b1, 2'b00);
    vecs[3] = mk(ia, 16'd0,    16'd0,    0, 2'b00, 0,  0, 2, 16'd0,    1'b0, 2'b00);
    vecs[4] = mk(ia, 16'd5,    16'd7,    0, 2'b10, 0,  0, 2, 16'd12,   1'b0, 2'b10);
    vecs[5] = mk(ia, 16'd4,    16'd4,    1, 2'b00, 2,  0, 1, 16'd0,    1'b1, 2'b00);
    vecs[6] = mk(ia, 16'hFFF0, 16'h0100, 0, 2'b00, 0,  0, 2, 16'hFFFF, 1'b0, 2'b00);
    vecs[7] = mk(ia, 16'd3,    16'd0,    0, 2'b00, 0,  1, 2, 16'd3,    1'b0, 2'b00);

    #12;
    chk("reset_outputs_zero", 64'(any_out()), 64'(0));
    @(negedge S_AXI_ACLK);
    @(negedge S_AXI_ACLK);
    S_AXI_ARESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i], ob);
      compare($sformatf("tbl%0d_", i), vecs[i], ob, 1'b1);
    end

    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < 6; j++) ri[j] = $urandom;
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 3))
          0:       rb[j] = 16'h0;
          1:       rb[j] = 16'($urandom_range(1, 20));
          2:       rb[j] = 16'($urandom);
          default: rb[j] = 16'hFF00 + 16'($urandom_range(0, 255));
        endcase
      end
      e = $urandom_range(0, 5);
      if (e > 2) e = 0;
      rv = mk(ri, rb[0], rb[1], e, ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 16'h0, 1'b0, 2'b00);
      run_job(rv, ob);
      compare($sformatf("rnd%0d_", i), rv, ob, 1'b0);
    end

    // Reset while a read command is waiting: valid must drop at once and never return.
    @(negedge S_AXI_ACLK);
    s_axi_start = 1'b1;
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge S_AXI_ACLK);
      if (rd_cmd_valid) seen = 1;
    end
    chk("seqA_valid_up", 64'(seen), 64'(1));
    #2 S_AXI_ARESET = 1'b1;
    #1 chk("seqA_valid_drop", 64'(rd_cmd_valid), 64'(0));
    s_axi_start = 1'b0;
    @(negedge S_AXI_ACLK);
    S_AXI_ARESET = 1'b0;
    rd_cmd_ready = 1'b1;
    moved = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge S_AXI_ACLK);
      if (rd_cmd_valid || wr_cmd_valid || dp_start || IRQ) moved = 1;
    end
    rd_cmd_ready = 1'b0;
    chk("seqA_no_reissue", 64'(moved), 64'(0));

    // Reset while waiting on layer 0, then a late dp_done after release.
    @(negedge S_AXI_ACLK);
    s_axi_start = 1'b1;
    seen = 0; cd = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge S_AXI_ACLK);
      rd_done = 0; rd_cmd_ready = 0;
      if (dp_start) seen = 1;
      else if (rd_cmd_valid) begin rd_cmd_ready = 1; cd = 2; end
      else if (cd > 0) begin cd--; if (cd == 0) rd_done = 1; end
    end
    rd_done = 0; rd_cmd_ready = 0;
    chk("seqB_dp0_started", 64'(seen), 64'(1));
    @(negedge S_AXI_ACLK);
    #2 S_AXI_ARESET = 1'b1;
    #1 chk("seqB_outputs_zero", 64'(any_out()), 64'(0));
    s_axi_start = 1'b0;
    @(negedge S_AXI_ACLK);
    S_AXI_ARESET = 1'b0;
    @(negedge S_AXI_ACLK);
    dp_done = 1'b1; dp_box_cnt = 16'd9;
    @(negedge S_AXI_ACLK);
    dp_done = 1'b0;
    moved = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge S_AXI_ACLK);
      if (rd_cmd_valid || wr_cmd_valid || dp_start || IRQ) moved = 1;
    end
    chk("seqB_late_dp_done_ignored", 64'(moved), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
